// File: rtl/feature_pad_gen_pkg.sv
// Shared definitions for the feature-map padding generator: map size table, widths and FSM states.
package feature_pkg;

    localparam int PIX_W     = 64;
    localparam int COL_SEL_W = 3;
    localparam int CNT_W     = 9;
    localparam int NUM_SIZES = 6;

    // Index 0 is the largest map; codes 6 and 7 fall back to index 0.
    localparam logic [NUM_SIZES-1:0][CNT_W-1:0] SIZE_TBL =
        {9'd13, 9'd26, 9'd52, 9'd104, 9'd208, 9'd416};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    function automatic logic [CNT_W-1:0] map_width(input logic [COL_SEL_W-1:0] sel);
        logic [COL_SEL_W-1:0] idx;
        idx = (sel < COL_SEL_W'(NUM_SIZES)) ? sel : '0;
        return SIZE_TBL[idx];
    endfunction

endpackage

// File: rtl/feature_pad_gen_if.sv
// FIFO read side and padded pixel stream of the padding generator.
interface feature_pad_gen_if
    import feature_pkg::*;
#(
    parameter int DATA_W    = 64,
    parameter int ROW_CNT_W = 7
);
    logic [DATA_W-1:0]    in_data;
    logic                 in_empty;
    logic                 in_rd_en;
    logic [DATA_W-1:0]    data_out;
    logic                 data_out_vld;
    logic [ROW_CNT_W-1:0] padding_row_cnt;
    logic [COL_SEL_W-1:0] col_select_out;

    modport master (
        input  in_data, in_empty,
        output in_rd_en, data_out, data_out_vld, padding_row_cnt, col_select_out
    );

    modport slave (
        output in_data, in_empty,
        input  in_rd_en, data_out, data_out_vld, padding_row_cnt, col_select_out
    );
endinterface

// File: rtl/feature_pad_cnt.sv
// Row/column slot counters over a P x P padded map, with last-slot and pad-slot flags.
// Latency: flags are combinational from the registered counters.
// Backpressure: none; advances on every enabled cycle.
module feature_pad_cnt
    import feature_pkg::*;
(
    input  logic             sclk,
    input  logic             s_rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] pad_size,
    output logic [CNT_W-1:0] row,
    output logic             last_slot,
    output logic             pad_slot
);
    logic [CNT_W-1:0] col_q;
    logic [CNT_W-1:0] row_q;
    logic [CNT_W-1:0] last_idx;
    logic             col_last;
    logic             row_last;

    assign last_idx  = pad_size - CNT_W'(1);
    assign col_last  = (col_q == last_idx);
    assign row_last  = (row_q == last_idx);
    assign last_slot = col_last && row_last;
    assign pad_slot  = (row_q == '0) || row_last || (col_q == '0) || col_last;
    assign row       = row_q;

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            col_q <= '0;
            row_q <= '0;
        end else if (clr) begin
            col_q <= '0;
            row_q <= '0;
        end else if (en) begin
            if (col_last) begin
                col_q <= '0;
                row_q <= row_last ? '0 : row_q + CNT_W'(1);
            end else begin
                col_q <= col_q + CNT_W'(1);
            end
        end
    end
endmodule

// File: rtl/feature_pad_gen.sv
// Zero-padding generator: streams a W x W map from a FIFO as a gapless (W+2)^2 padded burst.
// Latency: start -> first valid word 3 cycles; slot -> data_out 2 cycles; done 1 cycle after last word.
// Backpressure: none; FEATURE_PAD_UFLOW_EN substitutes zeros for starved reads and flags uflow_err.
module feature_pad_gen
    import feature_pkg::*;
#(
    parameter int DATA_W    = PIX_W,
    parameter int ROW_CNT_W = 7
) (
    input  logic                 sclk,
    input  logic                 s_rst_n,
    input  logic                 start,
    input  logic [COL_SEL_W-1:0] feature_col_select,
    output logic                 busy,
    output logic                 done,
`ifdef FEATURE_PAD_UFLOW_EN
    output logic                 uflow_err,
`endif
    feature_pad_gen_if.master    bus
);
    localparam logic [CNT_W-1:0] ROW_SAT = CNT_W'((1 << ROW_CNT_W) - 1);

    state_t               state_q, state_d;
    logic                 flush_q;
    logic                 done_q;
    logic [CNT_W-1:0]     p_q;
    logic [COL_SEL_W-1:0] col_sel_q;

    logic                 accept, run, body, starved, rd_en;
    logic                 last_slot, pad_slot;
    logic [CNT_W-1:0]     row;

    logic                 s1_vld, s1_pad;
    logic [CNT_W-1:0]     s1_row;
    logic [DATA_W-1:0]    pix;
    logic [DATA_W-1:0]    dout_q;
    logic                 vld_q;
    logic [ROW_CNT_W-1:0] rcnt_q;

    assign run    = (state_q == ST_RUN);
    assign accept = start && (state_q == ST_IDLE);
    assign body   = run && !pad_slot;
    assign pix    = bus.in_data;

`ifdef FEATURE_PAD_UFLOW_EN
    // A starved body slot still advances so the burst keeps its shape.
    assign starved = body && bus.in_empty;
`else
    assign starved = 1'b0;
`endif
    assign rd_en = body && !starved;

    feature_pad_cnt u_cnt (
        .sclk      (sclk),
        .s_rst_n   (s_rst_n),
        .clr       (accept),
        .en        (run),
        .pad_size  (p_q),
        .row       (row),
        .last_slot (last_slot),
        .pad_slot  (pad_slot)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start)     state_d = ST_RUN;
            ST_RUN:   if (last_slot) state_d = ST_FLUSH;
            ST_FLUSH: if (flush_q)   state_d = ST_IDLE;
            default:                 state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state_q   <= ST_IDLE;
            flush_q   <= 1'b0;
            done_q    <= 1'b0;
            p_q       <= '0;
            col_sel_q <= '0;
        end else begin
            state_q <= state_d;
            flush_q <= (state_q == ST_FLUSH) && !flush_q;
            done_q  <= (state_q == ST_FLUSH) && flush_q;
            if (accept) begin
                p_q       <= map_width(feature_col_select) + CNT_W'(2);
                col_sel_q <= feature_col_select;
            end
        end
    end

    // Stage 1 tracks the read in flight; stage 2 muxes the FIFO word against zero.
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            s1_vld <= 1'b0;
            s1_pad <= 1'b0;
            s1_row <= '0;
            dout_q <= '0;
            vld_q  <= 1'b0;
            rcnt_q <= '0;
        end else begin
            s1_vld <= run;
            s1_pad <= pad_slot || starved;
            s1_row <= row;
            dout_q <= (s1_vld && !s1_pad) ? pix : '0;
            vld_q  <= s1_vld;
            if (!s1_vld)
                rcnt_q <= '0;
            else if (s1_row > ROW_SAT)
                rcnt_q <= '1;
            else
                rcnt_q <= s1_row[ROW_CNT_W-1:0];
        end
    end

`ifdef FEATURE_PAD_UFLOW_EN
    logic uflow_q;
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n)
            uflow_q <= 1'b0;
        else if (accept)
            uflow_q <= 1'b0;
        else if (starved)
            uflow_q <= 1'b1;
    end
    assign uflow_err = uflow_q;
`endif

    assign bus.in_rd_en        = rd_en;
    assign bus.data_out        = dout_q;
    assign bus.data_out_vld    = vld_q;
    assign bus.padding_row_cnt = rcnt_q;
    assign bus.col_select_out  = col_sel_q;
    assign busy                = (state_q != ST_IDLE);
    assign done                = done_q;
endmodule

// File: tb/tb_feature_pad_gen.sv
// Scoreboard bench for feature_pad_gen: directed frames, back-to-back, saturation, reset, underflow.
module tb_feature_pad_gen;
    import feature_pkg::*;

    logic       sclk = 1'b0;
    logic       s_rst_n = 1'b0;
    logic       start = 1'b0;
    logic [2:0] feature_col_select = 3'd0;
    logic       busy;
    logic       done;
`ifdef FEATURE_PAD_UFLOW_EN
    logic       uflow_err;
`endif

    feature_pad_gen_if #(.DATA_W(64), .ROW_CNT_W(7)) bus ();

    feature_pad_gen #(.DATA_W(64), .ROW_CNT_W(7)) dut (
        .sclk               (sclk),
        .s_rst_n            (s_rst_n),
        .start              (start),
        .feature_col_select (feature_col_select),
        .busy               (busy),
        .done               (done),
`ifdef FEATURE_PAD_UFLOW_EN
        .uflow_err          (uflow_err),
`endif
        .bus                (bus)
    );

    always #5 sclk = ~sclk;

    typedef struct packed {
        logic [63:0] dat;
        logic [6:0]  row;
    } exp_t;

    exp_t        sb_q[$];
    logic [63:0] fifo_q[$];
    int          fifo_pushed = 0;
    int          fifo_popped = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    // First-word-latency-1 FIFO model.
    assign bus.in_empty = (fifo_pushed == fifo_popped);
    always @(posedge sclk) begin
        if (bus.in_rd_en) begin
            if (fifo_q.size() > 0) begin
                bus.in_data <= fifo_q.pop_front();
                fifo_popped <= fifo_popped + 1;
            end else begin
                bus.in_data <= '0;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, got, got, exp, exp, $time);
        end
    endtask

    // Monitor: pops one expected word for every valid output cycle.
    always @(negedge sclk) begin
        exp_t e;
        if (bus.data_out_vld) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sb_unexpected: got word 0x%0h, expected no output at %0t", bus.data_out, $time);
            end else begin
                e = sb_q.pop_front();
                check("sb_data", bus.data_out, e.dat);
                check("sb_row", 64'(bus.padding_row_cnt), 64'(e.row));
            end
        end else if (s_rst_n) begin
            check("idle_data", bus.data_out, 64'd0);
            check("idle_row", 64'(bus.padding_row_cnt), 64'd0);
        end
    end

    task automatic load_fifo(input int base, input int n);
        for (int i = 1; i <= n; i++) fifo_q.push_back(64'(base + i));
        fifo_pushed = fifo_pushed + n;
    endtask

    task automatic push_frame(input int w, input int base, input int avail);
        int   p;
        int   k;
        exp_t e;
        p = w + 2;
        k = 0;
        for (int r = 0; r < p; r++) begin
            for (int c = 0; c < p; c++) begin
                if (r == 0 || r == p - 1 || c == 0 || c == p - 1) begin
                    e.dat = 64'd0;
                end else begin
                    k++;
                    e.dat = (k <= avail) ? 64'(base + k) : 64'd0;
                end
                e.row = (r > 127) ? 7'd127 : 7'(r);
                sb_q.push_back(e);
            end
        end
    endtask

    task automatic start_frame(input logic [2:0] sel, input int w, input int base, input int avail);
        push_frame(w, base, avail);
        feature_col_select = sel;
        start = 1'b1;
        @(posedge sclk);
        #1;
        start = 1'b0;
        check("col_select_latched", 64'(bus.col_select_out), 64'(sel));
        check("busy_after_start", 64'(busy), 64'd1);
    endtask

    task automatic wait_frame(input int w, input int exp_rd, input bit poke, input logic [2:0] sel);
        int p;
        int k;
        int nvld;
        int nrd;
        bit seen;
        p = w + 2;
        k = 0;
        nvld = 0;
        nrd = 0;
        seen = 1'b0;
        while (!seen && k < p * p + 20) begin
            @(negedge sclk);
            k++;
            if (bus.data_out_vld) nvld++;
            if (bus.in_rd_en) nrd++;
            if (k == 2) check("vld_before_latency", 64'(bus.data_out_vld), 64'd0);
            if (k == 3) check("first_vld_cycle", 64'(bus.data_out_vld), 64'd1);
            if (poke && k == 50) begin
                feature_col_select = 3'd0;
                start = 1'b1;
            end
            if (poke && k == 51) begin
                start = 1'b0;
                check("start_ignored_busy", 64'(bus.col_select_out), 64'(sel));
            end
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout: got no done after %0d cycles, expected done at %0d", k, p * p + 3);
        end else begin
            check("done_cycle", 64'(k), 64'(p * p + 3));
            check("vld_count", 64'(nvld), 64'(p * p));
            check("rd_count", 64'(nrd), 64'(exp_rd));
            check("busy_at_done", 64'(busy), 64'd0);
        end
    endtask

    task automatic reset_checks();
        check("rst_data", bus.data_out, 64'd0);
        check("rst_vld", 64'(bus.data_out_vld), 64'd0);
        check("rst_row", 64'(bus.padding_row_cnt), 64'd0);
        check("rst_colsel", 64'(bus.col_select_out), 64'd0);
        check("rst_rd_en", 64'(bus.in_rd_en), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
`ifdef FEATURE_PAD_UFLOW_EN
        check("rst_uflow", 64'(uflow_err), 64'd0);
`endif
    endtask

    task automatic abort_frame();
        #2;
        s_rst_n = 1'b0;
        #1;
        reset_checks();
        sb_q.delete();
        fifo_q.delete();
        fifo_pushed = fifo_popped;
        @(negedge sclk);
        s_rst_n = 1'b1;
        @(negedge sclk);
    endtask

    initial begin
        int nvld;

        repeat (3) @(posedge sclk);
        @(negedge sclk);
        reset_checks();
        s_rst_n = 1'b1;
        @(negedge sclk);

        // Smallest map, words 1..169, with a start poked mid-frame.
        load_fifo(0, 169);
        start_frame(3'd5, 13, 0, 169);
        wait_frame(13, 169, 1'b1, 3'd5);
        check("sb_drained_w13", 64'(sb_q.size()), 64'd0);

        // Back-to-back: select 4, then select 3 started on the done cycle.
        load_fifo(1000, 676);
        start_frame(3'd4, 26, 1000, 676);
        wait_frame(26, 676, 1'b0, 3'd4);
        check("colsel_held_at_done", 64'(bus.col_select_out), 64'd4);
        load_fifo(2000, 2704);
        start_frame(3'd3, 52, 2000, 2704);
        wait_frame(52, 2704, 1'b0, 3'd3);

        // Row count saturation past row 127.
        load_fifo(0, 43264);
        start_frame(3'd1, 208, 0, 43264);
        wait_frame(208, 43264, 1'b0, 3'd1);

`ifdef FEATURE_PAD_UFLOW_EN
        load_fifo(5000, 100);
        start_frame(3'd5, 13, 5000, 100);
        wait_frame(13, 100, 1'b0, 3'd5);
        check("uflow_set", 64'(uflow_err), 64'd1);
        load_fifo(6000, 169);
        start_frame(3'd5, 13, 6000, 169);
        check("uflow_cleared", 64'(uflow_err), 64'd0);
        wait_frame(13, 169, 1'b0, 3'd5);
`endif

        // Asynchronous reset in mid-row of a select-2 frame.
        load_fifo(0, 10816);
        start_frame(3'd2, 104, 0, 10816);
        repeat (106 * 3 + 40) @(negedge sclk);
        abort_frame();

        // Illegal select decodes to the 416 map; row 1 col 1 must be word 1.
        load_fifo(0, 2000);
        start_frame(3'd7, 416, 0, 2000);
        nvld = 0;
        for (int i = 0; i < 2 * 418 + 10; i++) begin
            @(negedge sclk);
            if (bus.data_out_vld) nvld++;
        end
        check("sel7_vld_count", 64'(nvld), 64'(2 * 418 + 8));
        check("sel7_busy", 64'(busy), 64'd1);
        check("sel7_colsel", 64'(bus.col_select_out), 64'd7);
        abort_frame();

        check("sb_empty_end", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
